irq_controller: RTL
===================

Name: irq_controller

Overview:
Parametrised interrupt controller that replaces the four fixed, hardwired CPU interrupt lines with NUM_IRQ configurable channels.
- Sources: timers, frame-drawn, external pins.
- Per channel: edge/level mode, polarity, mask and pending state.
- Raises a single prioritised request with a channel ID to the CPU, and tracks in-service state until end-of-interrupt.
- Sits between the interrupt sources and the CPU. Registers are reached through the MemoryUnit I/O space.

Parameters:
- NUM_IRQ, 8, number of interrupt channels (2..32). ID_W = $clog2(NUM_IRQ) is derived locally.
- PRIO_LOW_FIRST, 1, 1: lowest channel index has highest priority; 0: highest index wins.

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous active-low reset.
- irq_in  input  NUM_IRQ  raw interrupt sources.
- reg_addr  input  2  register select: 0 PENDING, 1 MASK, 2 MODE, 3 POLARITY.
- reg_we  input  1  register write strobe, one cycle.
- reg_d  input  NUM_IRQ  register write data.
- reg_q  output  NUM_IRQ  register read data, registered, valid one cycle after reg_addr.
- irq_req  output  1  interrupt request to the CPU.
- irq_id  output  ID_W  winning channel; valid while irq_req=1.
- irq_ack  input  1  CPU accepts the request, one-cycle pulse.
- irq_eoi  input  1  CPU finished the handler, one-cycle pulse.
- in_service  output  1  a channel has been acknowledged and not yet ended.

Behaviour:
- Reset (async, nreset=0): all of the following clear to 0 immediately:
  - MASK = 0 (all channels disabled); MODE = 0 (all edge); POLARITY = 0 (active-high); PENDING = 0.
  - irq_req = 0, irq_id = 0, in_service = 0, reg_q = 0, edge-history register.
- Reset mid-handler drops in_service without needing EOI.
- Normalisation: s[i] = irq_in[i] XOR POLARITY[i].
- Edge mode (MODE[i]=0): PENDING[i] sets on the clock edge where s[i]=1 and the previous sampled s[i]=0. It stays set until cleared.
- Level mode (MODE[i]=1): PENDING[i] equals registered s[i] every cycle. Clears are ignored.
- Clearing PENDING:
  - Write to reg 0 is write-1-to-clear, edge-mode bits only.
  - Accepted irq_ack clears the acknowledged channel's edge pending bit.
  - A new edge and a clear in the same cycle: set wins.
- Eligible vector: E = PENDING & MASK. The priority encoder selects the winner per PRIO_LOW_FIRST.
- irq_req and irq_id are registered: irq_req(t+1) = (E != 0) and not in_service and not an ack in cycle t.
- Latency: a source edge appears in PENDING 1 cycle later and on irq_req 2 cycles later.
- State machine:
  - IDLE: irq_req may be high.
    - irq_ack while irq_req=1 → SERVICE: latch irq_id into svc_id, in_service=1, irq_req forced 0 on the next cycle.
    - irq_ack while irq_req=0 is ignored.
    - irq_eoi is ignored.
  - SERVICE: irq_req held 0, so there is no nesting.
    - irq_eoi → IDLE: in_service=0. If E is non-zero, irq_req reasserts on the following cycle.
    - irq_ack is ignored.
- irq_id does not change while irq_req=1 and the CPU has not acked. A higher-priority arrival may update it only while in IDLE.
- Masking the current winner while irq_req=1 drops irq_req on the next cycle.
- Register writes take effect on the next edge.
- MODE switch edge→level: PENDING[i] immediately follows the level.
- MODE switch level→edge: PENDING[i] is cleared and the edge history is reloaded with the current s[i], so no spurious edge is produced.
- Writing POLARITY reloads the edge history the same way, so no spurious edge is produced.
- Register bits above NUM_IRQ do not exist; reads return only defined widths.

Optional Feature:
IRQ_SYNC_EN:
- When defined, each irq_in bit passes through a two-flop synchronizer (reset to 0) before normalisation, for asynchronous pins such as nint1..4.
- Latency becomes 3 cycles to PENDING and 4 cycles to irq_req.
- When undefined, irq_in must already be synchronous to clk, and latency is as stated above.

Test Plan:
- Reset, then MASK=0x05 and MODE=0. Pulse irq_in[2] for 1 cycle → PENDING=0x04 after 1 cycle; irq_req=1, irq_id=2 after 2 cycles.
- Pulse channels 0 and 2 in the same cycle with MASK=0x05 → irq_id=0. Ack → in_service=1 and irq_req=0. EOI → irq_req=1, irq_id=2 on the next cycle.
- Edge pending on channel 3 with MASK=0. Read reg 0 → 0x08. Write reg 0 = 0x08 while a new edge on channel 3 arrives the same cycle → PENDING[3] stays 1.
- MODE[1]=1, POLARITY[1]=1, irq_in[1] held 0 → PENDING[1]=1 persistently. Write-1-to-clear has no effect. Set irq_in[1]=1 → PENDING[1]=0 after 1 cycle.
- irq_ack with irq_req=0 and irq_eoi in IDLE → no state change. Assert nreset while in_service=1 → all outputs 0 immediately.
- With IRQ_SYNC_EN, a single edge on irq_in[0] → irq_req rises exactly 4 cycles later.

Source files
------------

// File: rtl/irq_controller_if.sv
// irq_controller_if: groups the interrupt sources, the register access port
// and the CPU request/acknowledge handshake of irq_controller.
// master modport: the system side (sources + CPU); slave modport: the controller.

interface irq_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
);
    // Raw interrupt sources
    logic [NUM_IRQ-1:0] irq_in;
    // Register access port (MemoryUnit I/O space)
    logic [1:0]         reg_addr;
    logic               reg_we;
    logic [NUM_IRQ-1:0] reg_d;
    logic [NUM_IRQ-1:0] reg_q;
    // CPU handshake
    logic               irq_req;
    logic [ID_W-1:0]    irq_id;
    logic               irq_ack;
    logic               irq_eoi;
    logic               in_service;

    modport master (
        output irq_in,
        output reg_addr,
        output reg_we,
        output reg_d,
        output irq_ack,
        output irq_eoi,
        input  reg_q,
        input  irq_req,
        input  irq_id,
        input  in_service
    );

    modport slave (
        input  irq_in,
        input  reg_addr,
        input  reg_we,
        input  reg_d,
        input  irq_ack,
        input  irq_eoi,
        output reg_q,
        output irq_req,
        output irq_id,
        output in_service
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: NUM_IRQ-channel interrupt controller.
// Each channel has edge/level mode, polarity, mask and a pending bit. The
// eligible channels (PENDING & MASK) are priority-encoded into a single
// registered request + channel ID towards the CPU. After the CPU acknowledges,
// the controller stays in service (no nesting) until end-of-interrupt.
//
// Register map (reg_addr): 0 PENDING (write-1-to-clear, edge bits only),
//                          1 MASK, 2 MODE (1 = level), 3 POLARITY (1 = active-low).
//
// Optional build macro IRQ_SYNC_EN: adds a two-flop synchroniser on every
// irq_in bit for asynchronous pins (adds two cycles of latency). Without it,
// irq_in must already be synchronous to clk.

module irq_controller #(
    parameter int NUM_IRQ        = 8,
    parameter bit PRIO_LOW_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               nreset,
    irq_controller_if.slave    bus
);

    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    // Architectural state
    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pol_q, pol_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] rdata_q, rdata_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    svc_id_q, svc_id_d;
    logic               insvc_q, insvc_d;

    // Combinational helpers
    logic [NUM_IRQ-1:0] src_s;
    logic [NUM_IRQ-1:0] norm_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] clr_s;
    logic [NUM_IRQ-1:0] lvl_to_edge_s;
    logic [NUM_IRQ-1:0] elig_s;
    logic [NUM_IRQ-1:0] cur_onehot_s;
    logic [ID_W-1:0]    winner_s;
    logic               any_elig_s;
    logic               cur_hit_s;
    logic               wr_pend_s;
    logic               wr_mask_s;
    logic               wr_mode_s;
    logic               wr_pol_s;
    logic               ack_acc_s;

    // Priority encoder: lowest or highest set index wins depending on PRIO_LOW_FIRST.
    function automatic logic [ID_W-1:0] prio_pick(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] sel;
        sel = {ID_W{1'b0}};
        if (PRIO_LOW_FIRST) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    sel = ID_W'(i);
                end else begin
                    sel = sel;
                end
            end
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (vec[i]) begin
                    sel = ID_W'(i);
                end else begin
                    sel = sel;
                end
            end
        end
        return sel;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;

    // Two-flop synchroniser for asynchronous interrupt pins.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= {NUM_IRQ{1'b0}};
            sync2_q <= {NUM_IRQ{1'b0}};
        end else begin
            sync1_q <= bus.irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = bus.irq_in;
`endif

    // Register-write decode and acknowledge qualification.
    always_comb begin
        wr_pend_s    = bus.reg_we && (bus.reg_addr == 2'd0);
        wr_mask_s    = bus.reg_we && (bus.reg_addr == 2'd1);
        wr_mode_s    = bus.reg_we && (bus.reg_addr == 2'd2);
        wr_pol_s     = bus.reg_we && (bus.reg_addr == 2'd3);
        // An ack only counts when a request is actually being presented.
        ack_acc_s    = (state_q == ST_IDLE) && req_q && bus.irq_ack;
        cur_onehot_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
    end

    // Per-channel pending, configuration and edge-history next state.
    always_comb begin
        mask_d = wr_mask_s ? bus.reg_d : mask_q;
        mode_d = wr_mode_s ? bus.reg_d : mode_q;
        pol_d  = wr_pol_s  ? bus.reg_d : pol_q;

        norm_s = src_s ^ pol_q;
        rise_s = norm_s & ~hist_q;

        // Clears from software and from an accepted ack; a rising edge in the
        // same cycle still wins because rise_s is ORed in after the clear.
        clr_s = (wr_pend_s ? bus.reg_d    : {NUM_IRQ{1'b0}})
              | (ack_acc_s ? cur_onehot_s : {NUM_IRQ{1'b0}});

        // Leaving level mode discards the level-derived pending bit.
        lvl_to_edge_s = mode_q & ~mode_d;

        pend_d = (mode_d & norm_s)
               | (~mode_d & ~lvl_to_edge_s & (rise_s | (pend_q & ~clr_s)));

        // A polarity write reloads the history with the re-normalised input so
        // the polarity flip itself is never seen as an edge. The normal update
        // also covers the level->edge reload.
        hist_d = wr_pol_s ? (src_s ^ bus.reg_d) : norm_s;
    end

    // Eligible set and winner selection.
    always_comb begin
        elig_s     = pend_q & mask_q;
        any_elig_s = |elig_s;
        winner_s   = prio_pick(elig_s);
        cur_hit_s  = |(elig_s & cur_onehot_s);
    end

    // Request / service FSM: next state and registered request outputs.
    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        id_d     = id_q;
        svc_id_d = svc_id_q;
        case (state_q)
            ST_IDLE: begin
                if (ack_acc_s) begin
                    state_d  = ST_SERVICE;
                    svc_id_d = id_q;
                    req_d    = 1'b0;
                end else if (req_q) begin
                    // Presented ID is frozen; the request drops if the
                    // presented channel stops being eligible (masked/cleared).
                    req_d = cur_hit_s;
                end else begin
                    req_d = any_elig_s;
                    if (any_elig_s) begin
                        id_d = winner_s;
                    end else begin
                        id_d = id_q;
                    end
                end
            end
            ST_SERVICE: begin
                if (bus.irq_eoi) begin
                    state_d = ST_IDLE;
                    req_d   = any_elig_s;
                    if (any_elig_s) begin
                        id_d = winner_s;
                    end else begin
                        id_d = id_q;
                    end
                end else begin
                    state_d = ST_SERVICE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        insvc_d = (state_d == ST_SERVICE);
    end

    // Register read mux; data is presented one cycle after the address.
    always_comb begin
        case (bus.reg_addr)
            2'd0:    rdata_d = pend_q;
            2'd1:    rdata_d = mask_q;
            2'd2:    rdata_d = mode_q;
            2'd3:    rdata_d = pol_q;
            default: rdata_d = {NUM_IRQ{1'b0}};
        endcase
    end

    // State registers; everything clears asynchronously, including in-service.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            mask_q   <= {NUM_IRQ{1'b0}};
            mode_q   <= {NUM_IRQ{1'b0}};
            pol_q    <= {NUM_IRQ{1'b0}};
            pend_q   <= {NUM_IRQ{1'b0}};
            hist_q   <= {NUM_IRQ{1'b0}};
            rdata_q  <= {NUM_IRQ{1'b0}};
            req_q    <= 1'b0;
            id_q     <= {ID_W{1'b0}};
            svc_id_q <= {ID_W{1'b0}};
            insvc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            hist_q   <= hist_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            id_q     <= id_d;
            svc_id_q <= svc_id_d;
            insvc_q  <= insvc_d;
        end
    end

    assign bus.reg_q      = rdata_q;
    assign bus.irq_req    = req_q;
    assign bus.irq_id     = id_q;
    assign bus.in_service = insvc_q;

endmodule
